rc4_stream_gen: RTL and testbench
=================================

// Module: rc4_stream_gen
// PURPOSE
//  Parametrised RC4 keystream generator: next generation of rc4_new_design.
//  Variable-length key up to MAX_KEY_BYTES, optional RC4-drop[n] discard, and a
//  valid/ready byte stream output in place of a fixed block of bytes plus done.
//  Sits between key management (start/key) and the XOR datapath (ks_data consumer).
// PARAMETERS
//  MAX_KEY_BYTES  16  widest key accepted; key bus is MAX_KEY_BYTES*8 bits
//  KLEN_W         5   width of key_len; must hold MAX_KEY_BYTES
//  DROP_W         12  width of drop_n; max discard = 2**DROP_W-1 bytes
// PORTS
//  clk        in   1                 clock, rising edge
//  rst_n      in   1                 async active-low reset
//  start      in   1                 1-cycle request; sampled only in IDLE
//  key        in   MAX_KEY_BYTES*8   key byte k = key[8k+7:8k] (byte 0 = LSB)
//  key_len    in   KLEN_W            key bytes in use, 1..MAX_KEY_BYTES
//  drop_n     in   DROP_W            leading keystream bytes to discard
//  stop       in   1                 end current stream, return to IDLE
//  ks_data    out  8                 keystream byte
//  ks_valid   out  1                 ks_data valid
//  ks_ready   in   1                 consumer accepts ks_data when ks_valid&ks_ready
//  busy       out  1                 high in every state except IDLE
//  key_err    out  1                 1-cycle pulse: start with key_len 0 or >MAX
// BEHAVIOUR
//  Reset: state=IDLE, i=j=cnt=0, ks_data=0, ks_valid=0, busy=0, key_err=0.
//  key, key_len, drop_n are captured on the accepted start; later changes ignored.
//  FSM: IDLE -> INIT -> KSA -> DROP -> STREAM -> IDLE.
//   IDLE: start & legal key_len -> INIT. Illegal key_len -> key_err pulse, stay.
//   INIT: 256 cycles, S[cnt]=cnt, cnt 0..255, then j=0 and KSA.
//   KSA: 256 cycles, one swap per cycle: j=j+S[i]+K[i mod key_len] (mod 256),
//    swap S[i],S[j]; i 0..255. Then i=j=0. Go to DROP if drop_n!=0, else STREAM.
//   PRGA step, 1 cycle: i'=i+1; j'=j+S[i']; t=S[i']+S[j'] (pre-swap values);
//    swap S[i'],S[j']; byte = post-swap S[t]. Forward when t==i' or t==j'.
//   DROP: one PRGA step per cycle, result discarded; exits after exactly
//    drop_n steps.
//   STREAM: a PRGA step runs only when !ks_valid or (ks_valid&ks_ready), and its
//    byte loads ks_data with ks_valid=1. Full rate is 1 byte/cycle under
//    continuous ready. ks_data/ks_valid stay stable while ks_valid&!ks_ready.
//  Latency: start accepted at edge 0 -> first ks_valid at edge 512+drop_n+1.
//  stop: honoured in any non-IDLE state. Next cycle IDLE, ks_valid=0, and a
//   pending byte is discarded. stop with a handshake in the same cycle: that
//   byte is consumed, no new step, then IDLE.
//  start while busy: ignored (no restart, no error). start and stop together
//   in IDLE: start wins.
//  All index arithmetic is 8-bit wrap; key index wraps via a key_len counter
//   (no divider).
//  i wraps 255->0 in STREAM indefinitely; stream has no length limit.
//  Async reset mid-operation: immediate return to reset values. S contents are
//   undefined and rebuilt by the next INIT.
// STRUCTURE
//  Package rc4_pkg: state enum (IDLE/INIT/KSA/DROP/STREAM), SBOX_DEPTH=256,
//   BYTE_W=8.
//  Sub-module rc4_sbox: 256x8 flop array, 3 combinational read ports (i', j', t)
//   and 2 write ports (swap pair). Same-address double write on i'==j': the
//   value is unchanged.
//  Top holds the FSM, i/j/cnt/drop counters, the key register and the output
//   register.
// TESTING
//  1 key "Key" (key=24'h79654B, len 3), drop 0, ready=1 -> EB 9F 77 81 B7 34 CA
//    72 A7 19, then back-to-back.
//  2 key "Wiki" (32'h696B6957, len 4) -> 60 44 DB 6D 41 B7. First valid at edge
//    513 after start.
//  3 key 40'h0504030201 (len 5), drop 0 -> B2 39 63 05 F0 3D C0 27; with drop 4
//    -> first byte F0, at edge 517.
//  4 Case 1 with random ks_ready backpressure -> identical byte sequence, no
//    drops or duplicates, and ks_data stable while stalled.
//  5 key_len 0 and key_len MAX+1 -> key_err 1-cycle pulse, busy stays 0.
//    start during KSA -> ignored.
//  6 stop mid-STREAM, then restart with key "Key" -> sequence restarts at EB.
//    rst_n low during KSA -> all outputs 0 immediately.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared constants, state encoding and the PRGA output-select helper for the
// RC4 keystream generator.
package rc4_pkg;

    localparam int SBOX_DEPTH = 256;
    localparam int BYTE_W     = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_INIT   = 3'd1;
    localparam state_t ST_KSA    = 3'd2;
    localparam state_t ST_DROP   = 3'd3;
    localparam state_t ST_STREAM = 3'd4;

    // The output byte is S[t] after the swap; when t hits one of the two
    // swapped slots the array read is stale, so return the swapped value.
    function automatic logic [BYTE_W-1:0] prga_out(
        input logic [BYTE_W-1:0] t,
        input logic [BYTE_W-1:0] i_idx,
        input logic [BYTE_W-1:0] j_idx,
        input logic [BYTE_W-1:0] s_i,
        input logic [BYTE_W-1:0] s_j,
        input logic [BYTE_W-1:0] s_t
    );
        if (t == i_idx) begin
            return s_j;
        end else if (t == j_idx) begin
            return s_i;
        end else begin
            return s_t;
        end
    endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256-entry RC4 state array: three combinational read ports and a two-port
// write used for the per-cycle swap.
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic              clk,
    input  logic [BYTE_W-1:0] rd_a_addr,
    output logic [BYTE_W-1:0] rd_a_data,
    input  logic [BYTE_W-1:0] rd_b_addr,
    output logic [BYTE_W-1:0] rd_b_data,
    input  logic [BYTE_W-1:0] rd_t_addr,
    output logic [BYTE_W-1:0] rd_t_data,
    input  logic              wr_a_en,
    input  logic [BYTE_W-1:0] wr_a_addr,
    input  logic [BYTE_W-1:0] wr_a_data,
    input  logic              wr_b_en,
    input  logic [BYTE_W-1:0] wr_b_addr,
    input  logic [BYTE_W-1:0] wr_b_data
);

    logic [BYTE_W-1:0] mem_q [SBOX_DEPTH];
    logic [BYTE_W-1:0] mem_d [SBOX_DEPTH];

    // A swap with both addresses equal writes the same value twice, so the
    // port ordering below never changes the stored byte.
    always_comb begin
        mem_d = mem_q;
        if (wr_a_en) begin
            mem_d[wr_a_addr] = wr_a_data;
        end
        if (wr_b_en) begin
            mem_d[wr_b_addr] = wr_b_data;
        end
    end

    // Contents are rebuilt by INIT after every start, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_a_data = mem_q[rd_a_addr];
    assign rd_b_data = mem_q[rd_b_addr];
    assign rd_t_data = mem_q[rd_t_addr];

endmodule

// File: rtl/rc4_stream_gen.sv
// RC4 keystream generator: variable-length key, optional drop[n] discard and a
// valid/ready byte stream output.
module rc4_stream_gen
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    parameter int KLEN_W        = 5,
    parameter int DROP_W        = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [MAX_KEY_BYTES*8-1:0] key,
    input  logic [KLEN_W-1:0]          key_len,
    input  logic [DROP_W-1:0]          drop_n,
    input  logic                       stop,
    output logic [7:0]                 ks_data,
    output logic                       ks_valid,
    input  logic                       ks_ready,
    output logic                       busy,
    output logic                       key_err
);

    localparam int KEY_W = MAX_KEY_BYTES * BYTE_W;
    localparam logic [KLEN_W-1:0] MAX_LEN = KLEN_W'(MAX_KEY_BYTES);

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   i_q, i_d, j_q, j_d, cnt_q, cnt_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [KLEN_W-1:0]   klen_q, klen_d, kidx_q, kidx_d;
    logic [BYTE_W-1:0]   ks_data_q, ks_data_d;
    logic                ks_valid_q, ks_valid_d;
    logic                key_err_q, key_err_d;

    logic [BYTE_W-1:0]   key_byte, i_nx, j_ksa, j_prga, t_idx, prga_byte;
    logic [BYTE_W-1:0]   rd_a_addr, rd_a_data, rd_b_addr, rd_b_data, rd_t_data;
    logic                wr_a_en, wr_b_en;
    logic [BYTE_W-1:0]   wr_a_addr, wr_a_data, wr_b_addr, wr_b_data;

    rc4_sbox u_sbox (
        .clk       (clk),
        .rd_a_addr (rd_a_addr),
        .rd_a_data (rd_a_data),
        .rd_b_addr (rd_b_addr),
        .rd_b_data (rd_b_data),
        .rd_t_addr (t_idx),
        .rd_t_data (rd_t_data),
        .wr_a_en   (wr_a_en),
        .wr_a_addr (wr_a_addr),
        .wr_a_data (wr_a_data),
        .wr_b_en   (wr_b_en),
        .wr_b_addr (wr_b_addr),
        .wr_b_data (wr_b_data)
    );

    always_comb begin
        key_byte = '0;
        for (int b = 0; b < MAX_KEY_BYTES; b++) begin
            if (kidx_q == KLEN_W'(b)) begin
                key_byte = key_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

    // KSA reads S[i]; a PRGA step reads S[i+1]. Both feed the j update and swap.
    assign i_nx      = i_q + 8'd1;
    assign rd_a_addr = (state_q == ST_KSA) ? i_q : i_nx;
    assign j_ksa     = j_q + rd_a_data + key_byte;
    assign j_prga    = j_q + rd_a_data;
    assign rd_b_addr = (state_q == ST_KSA) ? j_ksa : j_prga;
    assign t_idx     = rd_a_data + rd_b_data;
    assign prga_byte = prga_out(t_idx, i_nx, j_prga, rd_a_data, rd_b_data, rd_t_data);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        cnt_d      = cnt_q;
        drop_cnt_d = drop_cnt_q;
        key_d      = key_q;
        klen_d     = klen_q;
        kidx_d     = kidx_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        key_err_d  = 1'b0;
        wr_a_en    = 1'b0;
        wr_a_addr  = i_nx;
        wr_a_data  = rd_b_data;
        wr_b_en    = 1'b0;
        wr_b_addr  = j_prga;
        wr_b_data  = rd_a_data;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((key_len == '0) || (key_len > MAX_LEN)) begin
                        key_err_d = 1'b1;
                    end else begin
                        state_d    = ST_INIT;
                        key_d      = key;
                        klen_d     = key_len;
                        drop_cnt_d = drop_n;
                        kidx_d     = '0;
                        i_d        = '0;
                        j_d        = '0;
                        cnt_d      = '0;
                    end
                end
            end
            ST_INIT: begin
                wr_a_en   = 1'b1;
                wr_a_addr = cnt_q;
                wr_a_data = cnt_q;
                cnt_d     = cnt_q + 8'd1;
                if (cnt_q == 8'hFF) begin
                    j_d     = '0;
                    state_d = ST_KSA;
                end
            end
            ST_KSA: begin
                wr_a_en   = 1'b1;
                wr_a_addr = i_q;
                wr_b_en   = 1'b1;
                wr_b_addr = j_ksa;
                i_d       = i_nx;
                j_d       = j_ksa;
                kidx_d    = (kidx_q == klen_q - KLEN_W'(1)) ? '0 : kidx_q + KLEN_W'(1);
                if (i_q == 8'hFF) begin
                    j_d     = '0;
                    state_d = (drop_cnt_q != '0) ? ST_DROP : ST_STREAM;
                end
            end
            ST_DROP: begin
                wr_a_en    = 1'b1;
                wr_b_en    = 1'b1;
                i_d        = i_nx;
                j_d        = j_prga;
                drop_cnt_d = drop_cnt_q - DROP_W'(1);
                if (drop_cnt_q == DROP_W'(1)) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // A new byte is produced only when the output register is free.
                if (!ks_valid_q || ks_ready) begin
                    wr_a_en    = 1'b1;
                    wr_b_en    = 1'b1;
                    i_d        = i_nx;
                    j_d        = j_prga;
                    ks_data_d  = prga_byte;
                    ks_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (stop && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            ks_valid_d = 1'b0;
            wr_a_en    = 1'b0;
            wr_b_en    = 1'b0;
            i_d        = '0;
            j_d        = '0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            cnt_q      <= '0;
            drop_cnt_q <= '0;
            key_q      <= '0;
            klen_q     <= '0;
            kidx_q     <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            cnt_q      <= cnt_d;
            drop_cnt_q <= drop_cnt_d;
            key_q      <= key_d;
            klen_q     <= klen_d;
            kidx_q     <= kidx_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
            key_err_q  <= key_err_d;
        end
    end

    assign ks_data  = ks_data_q;
    assign ks_valid = ks_valid_q;
    assign key_err  = key_err_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rc4_stream_gen.sv
// Self-checking bench for rc4_stream_gen: known vectors, a behavioural RC4
// model for random keys, backpressure, stop, key errors and reset.
module tb_rc4_stream_gen;

    localparam int MAXK = 16;
    localparam int KLW  = 5;
    localparam int DW   = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              ks_ready;
    logic [MAXK*8-1:0] key = '0;
    logic [KLW-1:0]    key_len = '0;
    logic [DW-1:0]     drop_n = '0;
    logic [7:0]        ks_data;
    logic              ks_valid, busy, key_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_rx    = 0;
    bit   bp_en   = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] known_q[$];
    logic [7:0] ref_q[$];

    localparam logic [MAXK*8-1:0] KEY_KEY  = 128'h79654B;
    localparam logic [MAXK*8-1:0] KEY_WIKI = 128'h696B6957;
    localparam logic [MAXK*8-1:0] KEY_SEQ  = 128'h0504030201;

    always #5 clk = ~clk;

    rc4_stream_gen #(.MAX_KEY_BYTES(MAXK), .KLEN_W(KLW), .DROP_W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key      (key),
        .key_len  (key_len),
        .drop_n   (drop_n),
        .stop     (stop),
        .ks_data  (ks_data),
        .ks_valid (ks_valid),
        .ks_ready (ks_ready),
        .busy     (busy),
        .key_err  (key_err)
    );

    always @(negedge clk) begin
        ks_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: handshake pops, stall compares against the head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && ks_valid) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ks_extra: got %02h expected no byte", ks_data);
                    if (ks_ready) n_rx++;
                end else if (ks_ready) begin
                    check("ks_byte", {24'h0, ks_data}, {24'h0, exp_q.pop_front()});
                    n_rx++;
                end else begin
                    check("ks_stall", {24'h0, ks_data}, {24'h0, exp_q[0]});
                end
            end
        end
    end

    // Plain RC4 reference: KSA, then PRGA with the first d bytes thrown away.
    task automatic model(input logic [MAXK*8-1:0] k, input int len, input int d, input int n);
        int s[256];
        int i, j, t, tmp;
        logic [7:0] kb;
        ref_q.delete();
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = k[(x % len)*8 +: 8];
            j = (j + s[x] + int'(kb)) % 256;
            tmp = s[x]; s[x] = s[j]; s[j] = tmp;
        end
        i = 0;
        j = 0;
        for (int x = 0; x < d + n; x++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            tmp = s[i]; s[i] = s[j]; s[j] = tmp;
            t = (s[i] + s[j]) % 256;
            if (x >= d) ref_q.push_back(8'(s[t]));
        end
    endtask

    task automatic load_exp(input logic [MAXK*8-1:0] k, input int len, input int d, input int n);
        model(k, len, d, n);
        exp_q.delete();
        for (int x = 0; x < n; x++) begin
            exp_q.push_back((x < known_q.size()) ? known_q[x] : ref_q[x]);
        end
        known_q.delete();
    endtask

    task automatic do_start(input logic [MAXK*8-1:0] k, input int len, input int d);
        @(negedge clk);
        key = k;
        key_len = len[KLW-1:0];
        drop_n = d[DW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = {4{$urandom()}};
        key_len = KLW'($urandom_range(0, 31));
        drop_n = DW'($urandom_range(0, 4095));
    endtask

    task automatic wait_valid(input string name, input int exp_edges);
        int n = 0;
        while (n < 6000) begin
            @(posedge clk);
            n++;
            #1;
            if (ks_valid) break;
        end
        check(name, n, exp_edges);
    endtask

    task automatic wait_rx(input int target);
        int c = 0;
        while (n_rx < target && c < 8000) begin
            @(negedge clk);
            c++;
        end
        check("rx_done", {31'h0, n_rx >= target}, 32'h1);
    endtask

    task automatic do_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #2;
        exp_q.delete();
        check("stop_busy", {31'h0, busy}, 32'h0);
        check("stop_valid", {31'h0, ks_valid}, 32'h0);
    endtask

    task automatic run(input string name, input logic [MAXK*8-1:0] k, input int len,
                       input int d, input int n);
        load_exp(k, len, d, n + 8);
        n_rx = 0;
        do_start(k, len, d);
        wait_valid(name, 513 + d);
        wait_rx(n);
        do_stop();
    endtask

    task automatic bad_start(input int len);
        @(negedge clk);
        key_len = len[KLW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("key_err_pulse", {31'h0, key_err}, 32'h1);
        check("key_err_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("key_err_clear", {31'h0, key_err}, 32'h0);
        check("key_err_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", {31'h0, ks_valid}, 32'h0);
        check("rst_data", {24'h0, ks_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_key_err", {31'h0, key_err}, 32'h0);
        rst_n = 1'b1;

        known_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run("lat_key", KEY_KEY, 3, 0, 30);

        known_q = '{8'h60, 8'h44, 8'hDB, 8'h6D, 8'h41, 8'hB7};
        run("lat_wiki", KEY_WIKI, 4, 0, 6);

        known_q = '{8'hB2, 8'h39, 8'h63, 8'h05, 8'hF0, 8'h3D, 8'hC0, 8'h27};
        run("lat_seq", KEY_SEQ, 5, 0, 8);

        known_q = '{8'hF0, 8'h3D, 8'hC0, 8'h27};
        run("lat_drop4", KEY_SEQ, 5, 4, 4);

        bp_en = 1'b1;
        known_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run("lat_bp", KEY_KEY, 3, 0, 40);
        bp_en = 1'b0;

        bad_start(0);
        bad_start(MAXK + 1);

        // start during KSA must not restart with the new key
        load_exp(KEY_KEY, 3, 0, 20);
        n_rx = 0;
        do_start(KEY_KEY, 3, 0);
        repeat (300) @(negedge clk);
        check("ksa_busy", {31'h0, busy}, 32'h1);
        key = KEY_WIKI;
        key_len = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ksa_no_err", {31'h0, key_err}, 32'h0);
        wait_rx(12);
        do_stop();

        // stop mid-stream with a stalled byte, then restart from scratch
        load_exp(KEY_WIKI, 4, 0, 20);
        n_rx = 0;
        do_start(KEY_WIKI, 4, 0);
        bp_en = 1'b1;
        wait_rx(5);
        do_stop();
        bp_en = 1'b0;
        known_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run("lat_restart", KEY_KEY, 3, 0, 10);

        // async reset in KSA clears every output at once
        do_start(KEY_KEY, 3, 0);
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, ks_valid}, 32'h0);
        check("arst_data", {24'h0, ks_data}, 32'h0);
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_key_err", {31'h0, key_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        known_q = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
        run("lat_after_rst", KEY_KEY, 3, 0, 10);

        for (int it = 0; it < 5; it++) begin
            int len;
            int d;
            logic [MAXK*8-1:0] k;
            len = $urandom_range(1, MAXK);
            d = (it == 3) ? 4095 : $urandom_range(0, 60);
            k = {$urandom(), $urandom(), $urandom(), $urandom()};
            bp_en = ($urandom_range(0, 1) == 1);
            run("lat_rand", k, len, d, 24);
        end
        bp_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
